// File: rtl/minisys_mem_wb_if.sv
// MEM/WB stage bundle: M-stage controls and load data in, W-stage results out.
// The master drives the M side and the slave (the pipeline register) drives the W side.
interface minisys_mem_wb_if;
    logic        stallW;
    logic        flushW;
    logic        regwriteM;
    logic        mem2regM;
    logic [4:0]  write_regM;
    logic [31:0] alu_outM;
    logic [31:0] mem_rdataM;
    logic [2:0]  load_typeM;

    logic        regwriteW;
    logic        mem2regW;
    logic [4:0]  write_regW;
    logic [31:0] alu_outW;
    logic [31:0] read_dataW;
    logic        load_errW;
    logic [31:0] bad_addrW;
    logic [31:0] load_cntW;

    modport master (
        output stallW, flushW, regwriteM, mem2regM, write_regM, alu_outM, mem_rdataM, load_typeM,
        input  regwriteW, mem2regW, write_regW, alu_outW, read_dataW, load_errW, bad_addrW, load_cntW
    );

    modport slave (
        input  stallW, flushW, regwriteM, mem2regM, write_regM, alu_outM, mem_rdataM, load_typeM,
        output regwriteW, mem2regW, write_regW, alu_outW, read_dataW, load_errW, bad_addrW, load_cntW
    );
endinterface

// File: rtl/minisys_mem_wb.sv
// MEM/WB pipeline register: sub-word load extraction, misaligned-load detection
// and a retired-load counter, all presented as purely registered W-stage outputs.
module minisys_mem_wb (
    input  logic           clk,
    input  logic           rst_n,
    minisys_mem_wb_if.slave bus
);
    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } loadType_e;

    logic [1:0]  lane;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic        fault;
    logic        wenNext;
    logic        cntInc;

    logic        regWrite;
    logic        mem2reg;
    logic [4:0]  writeReg;
    logic [31:0] aluOut;
    logic [31:0] readData;
    logic        loadErr;
    logic [31:0] badAddr;
    logic [31:0] loadCnt;

    always_comb begin
        lane     = bus.alu_outM[1:0];
        byteSel  = bus.mem_rdataM[{lane, 3'b000} +: 8];
        halfSel  = lane[1] ? bus.mem_rdataM[31:16] : bus.mem_rdataM[15:0];
        loadData = '0;
        fault    = 1'b0;
        if (!bus.mem2regM) begin
            case (bus.load_typeM)
                LT_LW:   begin loadData = bus.mem_rdataM;            fault = (lane != 2'b00); end
                LT_LB:         loadData = {{24{byteSel[7]}}, byteSel};
                LT_LBU:        loadData = {24'b0, byteSel};
                LT_LH:   begin loadData = {{16{halfSel[15]}}, halfSel}; fault = lane[0]; end
                LT_LHU:  begin loadData = {16'b0, halfSel};             fault = lane[0]; end
                default:       fault = 1'b1;
            endcase
        end
        // A faulting load must leave no trace in the register file or the counter.
        if (fault) loadData = '0;
        wenNext = bus.regwriteM && (bus.write_regM != 5'd0) && !fault;
        cntInc  = !bus.mem2regM && bus.regwriteM && !fault;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWrite <= 1'b0;
            mem2reg  <= 1'b1;
            writeReg <= '0;
            aluOut   <= '0;
            readData <= '0;
            loadErr  <= 1'b0;
            badAddr  <= '0;
            loadCnt  <= '0;
        end else if (bus.flushW) begin
            regWrite <= 1'b0;
            mem2reg  <= 1'b1;
            writeReg <= '0;
            aluOut   <= '0;
            readData <= '0;
            loadErr  <= 1'b0;
            badAddr  <= '0;
        end else if (!bus.stallW) begin
            regWrite <= wenNext;
            mem2reg  <= bus.mem2regM;
            writeReg <= bus.write_regM;
            aluOut   <= bus.alu_outM;
            readData <= loadData;
            loadErr  <= fault;
            badAddr  <= fault ? bus.alu_outM : 32'd0;
            loadCnt  <= loadCnt + {31'd0, cntInc};
        end
    end

    assign bus.regwriteW  = regWrite;
    assign bus.mem2regW   = mem2reg;
    assign bus.write_regW = writeReg;
    assign bus.alu_outW   = aluOut;
    assign bus.read_dataW = readData;
    assign bus.load_errW  = loadErr;
    assign bus.bad_addrW  = badAddr;
    assign bus.load_cntW  = loadCnt;
endmodule

// File: tb/tb_minisys_mem_wb.sv
// Randomized bench for minisys_mem_wb with an arithmetic reference model and
// literal spot checks that pin the model to known answers.
module tb_minisys_mem_wb;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    minisys_mem_wb_if bus();
    minisys_mem_wb dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wen;
        logic        m2r;
        logic [4:0]  wr;
        logic [31:0] alu;
        logic [31:0] rd;
        logic        err;
        logic [31:0] bad;
        logic [31:0] cnt;
    } wb_t;

    wb_t         m;
    logic [31:0] cntBias = 32'd0;
    int          nCmp = 0;
    int          nBad = 0;
    bit          started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic wb_t idleState(input logic [31:0] cnt);
        wb_t r;
        r = '0;
        r.m2r = 1'b1;
        r.cnt = cnt;
        return r;
    endfunction

    // Reference: what the W stage must hold after capturing one M-stage instruction.
    function automatic wb_t capture(input wb_t prev, input logic rw, input logic m2r,
                                    input logic [4:0] wr, input logic [31:0] addr,
                                    input logic [31:0] w, input logic [2:0] lt);
        wb_t r;
        int unsigned a, b, h;
        logic [31:0] d;
        bit ok;
        r = '0;
        r.cnt = prev.cnt;
        r.m2r = m2r;
        r.wr  = wr;
        r.alu = addr;
        if (m2r) begin
            r.wen = rw && (wr != 5'd0);
        end else begin
            a  = addr % 4;
            b  = (w >> (8 * a)) % 256;
            h  = (w >> (8 * a)) % 65536;
            ok = 1'b1;
            d  = 32'd0;
            case (lt)
                3'd0: begin ok = (a == 0); d = w; end
                3'd1: d = (b < 128) ? b : b + 32'hFFFF_FF00;
                3'd2: d = b;
                3'd3: begin ok = (a % 2 == 0); d = (h < 32768) ? h : h + 32'hFFFF_0000; end
                3'd4: begin ok = (a % 2 == 0); d = h; end
                default: ok = 1'b0;
            endcase
            if (ok) begin
                r.rd  = d;
                r.wen = rw && (wr != 5'd0);
                if (rw) r.cnt = prev.cnt + 32'd1;
            end else begin
                r.err = 1'b1;
                r.bad = addr;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            m <= idleState(32'd0);
        else if (bus.flushW)   m <= idleState(m.cnt);
        else if (!bus.stallW)  m <= capture(m, bus.regwriteM, bus.mem2regM, bus.write_regM,
                                            bus.alu_outM, bus.mem_rdataM, bus.load_typeM);
    end

    always @(negedge clk) begin
        if (started) begin
            chk("regwriteW",  {31'd0, bus.regwriteW}, {31'd0, m.wen});
            chk("mem2regW",   {31'd0, bus.mem2regW},  {31'd0, m.m2r});
            chk("write_regW", {27'd0, bus.write_regW}, {27'd0, m.wr});
            chk("alu_outW",   bus.alu_outW,  m.alu);
            chk("read_dataW", bus.read_dataW, m.rd);
            chk("load_errW",  {31'd0, bus.load_errW}, {31'd0, m.err});
            chk("bad_addrW",  bus.bad_addrW, m.bad);
            chk("load_cntW",  bus.load_cntW, m.cnt + cntBias);
        end
    end

    task automatic drive(input logic st, input logic fl, input logic rw, input logic m2r,
                         input logic [4:0] wr, input logic [31:0] addr,
                         input logic [31:0] w, input logic [2:0] lt);
        bus.stallW     = st;
        bus.flushW     = fl;
        bus.regwriteM  = rw;
        bus.mem2regM   = m2r;
        bus.write_regM = wr;
        bus.alu_outM   = addr;
        bus.mem_rdataM = w;
        bus.load_typeM = lt;
        @(posedge clk);
        #1;
    endtask

    task automatic randCycle();
        logic st, fl, rw, m2r;
        logic [2:0] lt;
        st  = ($urandom_range(0, 99) < 15);
        fl  = ($urandom_range(0, 99) < 8);
        rw  = ($urandom_range(0, 99) < 85);
        m2r = ($urandom_range(0, 99) < 40);
        lt  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        drive(st, fl, rw, m2r, 5'($urandom_range(0, 31)), $urandom, $urandom, lt);
    endtask

    logic [2:0]  swType [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [1:0]  swLane [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] swExp  [5] = '{32'h0000_007F, 32'hFFFF_FFFF, 32'h0000_0080,
                                32'hFFFF_80FF, 32'h0000_7F01};

    initial begin
        bus.stallW = 1'b0; bus.flushW = 1'b0; bus.regwriteM = 1'b0; bus.mem2regM = 1'b1;
        bus.write_regM = '0; bus.alu_outM = '0; bus.mem_rdataM = '0; bus.load_typeM = '0;

        // Reset lands mid-cycle, before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst regwriteW",  {31'd0, bus.regwriteW}, 32'd0);
        chk("rst mem2regW",   {31'd0, bus.mem2regW},  32'd1);
        chk("rst write_regW", {27'd0, bus.write_regW}, 32'd0);
        chk("rst alu_outW",   bus.alu_outW,  32'd0);
        chk("rst read_dataW", bus.read_dataW, 32'd0);
        chk("rst load_errW",  {31'd0, bus.load_errW}, 32'd0);
        chk("rst bad_addrW",  bus.bad_addrW, 32'd0);
        chk("rst load_cntW",  bus.load_cntW, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        started = 1'b1;

        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0100 | {30'd0, swLane[i]},
                  32'h80FF_7F01, swType[i]);
            chk("subword read_dataW", bus.read_dataW, swExp[i]);
        end
        chk("subword load_cntW", bus.load_cntW, 32'd5);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_1002, 32'hDEAD_BEEF, 3'd0);
        chk("lw misalign load_errW",  {31'd0, bus.load_errW}, 32'd1);
        chk("lw misalign bad_addrW",  bus.bad_addrW, 32'h0000_1002);
        chk("lw misalign regwriteW",  {31'd0, bus.regwriteW}, 32'd0);
        chk("lw misalign read_dataW", bus.read_dataW, 32'd0);
        chk("lw misalign load_cntW",  bus.load_cntW, 32'd5);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_2001, 32'h1234_5678, 3'd3);
        chk("lh misalign load_errW", {31'd0, bus.load_errW}, 32'd1);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd4, 32'h0000_3000, 32'h1234_5678, 3'd6);
        chk("reserved load_errW", {31'd0, bus.load_errW}, 32'd1);
        chk("reserved load_cntW", bus.load_cntW, 32'd5);

        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_4000, 32'h0000_00AB, 3'd2);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, $urandom, $urandom, 3'd0);
            chk("stall read_dataW", bus.read_dataW, 32'h0000_00AB);
            chk("stall load_cntW", bus.load_cntW, 32'd6);
        end

        drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_5000, 32'h1111_1111, 3'd0);
        chk("flush mem2regW",  {31'd0, bus.mem2regW}, 32'd1);
        chk("flush alu_outW",  bus.alu_outW, 32'd0);
        chk("flush load_cntW", bus.load_cntW, 32'd6);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd6, 32'h0000_0040, 32'd0, 3'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 32'h0000_5000, 32'h1111_1111, 3'd0);
        chk("flush+stall regwriteW", {31'd0, bus.regwriteW}, 32'd0);
        chk("flush+stall write_regW", {27'd0, bus.write_regW}, 32'd0);

        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'h0000_0077, 32'd0, 3'd0);
        chk("zero-reg regwriteW", {31'd0, bus.regwriteW}, 32'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h1234_5678, 32'hFFFF_FFFF, 3'd1);
        chk("alu-op alu_outW",   bus.alu_outW, 32'h1234_5678);
        chk("alu-op read_dataW", bus.read_dataW, 32'd0);
        chk("alu-op regwriteW",  {31'd0, bus.regwriteW}, 32'd1);
        chk("alu-op load_cntW",  bus.load_cntW, 32'd6);

        for (int i = 0; i < 400; i++) randCycle();

        // Reset while stalled, released between edges.
        bus.stallW = 1'b1;
        #3 rst_n = 1'b0;
        #1;
        chk("stall-rst mem2regW",  {31'd0, bus.mem2regW}, 32'd1);
        chk("stall-rst load_cntW", bus.load_cntW, 32'd0);
        chk("stall-rst regwriteW", {31'd0, bus.regwriteW}, 32'd0);
        #2 rst_n = 1'b1;
        #4;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0000_0002, 32'hC3A5_0000, 3'd4);
        chk("post-rst read_dataW", bus.read_dataW, 32'h0000_C3A5);
        chk("post-rst load_cntW",  bus.load_cntW, 32'd1);

        // Preload the counter one short of wrapping.
        force dut.loadCnt = 32'hFFFF_FFFF;
        #1;
        release dut.loadCnt;
        cntBias = 32'hFFFF_FFFF - m.cnt;
        chk("preload load_cntW", bus.load_cntW, 32'hFFFF_FFFF);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0000_0003, 32'h7700_0000, 3'd1);
        chk("wrap load_cntW",  bus.load_cntW, 32'd0);
        chk("wrap read_dataW", bus.read_dataW, 32'h0000_0077);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd8, 32'h0000_0000, 32'h0000_0001, 3'd0);
        chk("after-wrap load_cntW", bus.load_cntW, 32'd1);

        for (int i = 0; i < 150; i++) randCycle();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'd0, 32'd0, 3'd0);

        started = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
